// File: rtl/regfile_pkg.sv
// Shared definitions for the 32 x 32-bit register bank: widths, the
// write-back queue entry and the one-hot write-enable vector type.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef logic [NUM_REGS-1:0] reg_onehot_t;

endpackage

// File: rtl/reg_addr_decoder.sv
// Register address to one-hot select decoder; shared by the write port
// and the register bank.
module reg_addr_decoder
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output reg_onehot_t       onehot_o
);

  // Exactly one bit set, at the position named by the address.
  always_comb begin
    onehot_o         = '0;
    onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_write_port.sv
// Write-back port of the register bank. Buffers accepted writes in a small
// in-order queue, drains one per cycle as a registered one-hot strobe and
// answers hazard queries against everything not yet committed.
module reg_write_port
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       bank_stall,
  output reg_onehot_t                we_onehot,
  output logic [DATA_W-1:0]          we_data,
  input  logic [ADDR_W-1:0]          q_addr,
  output logic                       q_hit,
  output logic [DATA_W-1:0]          q_data,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  reg_onehot_t        we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  reg_onehot_t        head_onehot;
  wb_entry_t          head_entry;
  logic               push, pop;
  logic [PTR_W-1:0]   hz_idx;

  // Ready is purely a function of occupancy; a same-cycle pop does not help.
  assign wr_ready   = (cnt_q < CNT_W'(DEPTH)) && rst_n;
  // Writes to r0 complete the handshake but never enter the queue.
  assign push       = wr_valid && wr_ready && (wr_addr != '0);
  assign pop        = (cnt_q != '0) && !bank_stall;
  assign head_entry = mem_q[head_q];
  assign we_onehot  = we_q;
  assign we_data    = wdata_q;
  assign pend_cnt   = cnt_q;

  reg_addr_decoder u_dec (
    .addr_i   (head_entry.addr),
    .onehot_o (head_onehot)
  );

  // Next-state for pointers, occupancy and the strobe stage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    we_d    = '0;
    wdata_d = wdata_q;
    if (pop) begin
      head_d  = head_q + PTR_W'(1);
      we_d    = head_onehot;
      wdata_d = head_entry.data;
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and strobe registers; reset drops the queue and any pending strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Queue storage carries no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{addr: wr_addr, data: wr_data};
    end
  end

  // Hazard search, oldest to youngest so the youngest match overrides.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    hz_idx = head_q;
    if (q_addr != '0) begin
      if (we_q[q_addr]) begin
        q_hit  = 1'b1;
        q_data = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        hz_idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < cnt_q) && (mem_q[hz_idx].addr == q_addr)) begin
          q_hit  = 1'b1;
          q_data = mem_q[hz_idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_port.sv
// Self-checking bench for reg_write_port: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_reg_write_port;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        bank_stall;
  logic [31:0] we_onehot;
  logic [31:0] we_data;
  logic [4:0]  q_addr;
  logic        q_hit;
  logic [31:0] q_data;
  logic [1:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes as {addr,data}, plus the last issued write.
  logic [36:0] mq [$];
  bit          inf_v;
  logic [4:0]  inf_a;
  logic [31:0] inf_d;

  reg_write_port #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .bank_stall (bank_stall),
    .we_onehot  (we_onehot),
    .we_data    (we_data),
    .q_addr     (q_addr),
    .q_hit      (q_hit),
    .q_data     (q_data),
    .pend_cnt   (pend_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    return (rst_n === 1'b1) && (mq.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_we();
    return inf_v ? (32'd1 << inf_a) : 32'd0;
  endfunction

  function automatic bit m_hit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i][36:32] == a) return 1'b1;
    return inf_v && (inf_a == a);
  endfunction

  function automatic logic [31:0] m_qdata(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i][36:32] == a) return mq[i][31:0];
    if (inf_v && inf_a == a) return inf_d;
    return 32'd0;
  endfunction

  // Advance one clock edge and update the model from the inputs seen at it.
  task automatic tick();
    bit          acc, pp;
    logic [36:0] e;
    acc = wr_valid && m_ready();
    pp  = (mq.size() > 0) && !bank_stall;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      mq.delete();
      inf_v = 1'b0;
      inf_d = 32'd0;
    end else begin
      inf_v = 1'b0;
      if (pp) begin
        e     = mq.pop_front();
        inf_v = 1'b1;
        inf_a = e[36:32];
        inf_d = e[31:0];
      end
      if (acc && wr_addr != 5'd0) mq.push_back({wr_addr, wr_data});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; bank_stall = 1'b0;
    wr_addr = '0; wr_data = '0; q_addr = 5'd5;
    tick();
    tick();
    checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", pend_cnt); end
    checks++; if (we_onehot !== 32'd0) begin errors++; $display("FAIL reset_we got %h exp 0", we_onehot); end
    checks++; if (we_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", we_data); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b exp 0", wr_ready); end
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL reset_qhit got %b exp 0", q_hit); end
    rst_n = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high got %b exp 1", wr_ready); end
  endtask

  task automatic test_single();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; q_addr = 5'd5;
    #1;
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (we_onehot !== 32'd0) begin errors++; $display("FAIL single_early got %h exp 0", we_onehot); end
    checks++; if (q_hit !== 1'b1 || q_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hazard got %b/%h exp 1/deadbeef", q_hit, q_data); end
    tick();
    checks++; if (we_onehot !== 32'h00000020 || we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_strobe got %h/%h exp 00000020/deadbeef", we_onehot, we_data); end
    tick();
    checks++; if (we_onehot !== 32'd0 || we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_after got %h/%h exp 0/deadbeef", we_onehot, we_data); end
  endtask

  task automatic test_addr0();
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; q_addr = 5'd0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL addr0_ready got %b exp 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL addr0_pend got %0d exp 0", pend_cnt); end
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL addr0_qhit got %b exp 0", q_hit); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (we_onehot !== 32'd0) begin errors++; $display("FAIL addr0_strobe got %h exp 0", we_onehot); end
    end
  endtask

  task automatic test_stall_full();
    logic [31:0] d [3];
    logic [31:0] exp_we [4];
    exp_we[0] = 32'h8; exp_we[1] = 32'h80; exp_we[2] = 32'h1000; exp_we[3] = 32'h0;
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    bank_stall = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd3; wr_data = d[0]; #1; tick();
    wr_addr = 5'd7; wr_data = d[1]; #1; tick();
    wr_addr = 5'd12; wr_data = d[2];
    #1;
    checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL full_pend got %0d exp 2", pend_cnt); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", wr_ready); end
    tick();
    checks++; if (pend_cnt !== 2'd2 || we_onehot !== 32'd0) begin errors++; $display("FAIL full_held got %0d/%h exp 2/0", pend_cnt, we_onehot); end
    bank_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) wr_valid = 1'b0;
      checks++; if (we_onehot !== exp_we[k]) begin errors++; $display("FAIL full_drain%0d got %h exp %h", k, we_onehot, exp_we[k]); end
      if (k < 3) begin
        checks++; if (we_data !== d[k]) begin errors++; $display("FAIL full_data%0d got %h exp %h", k, we_data, d[k]); end
      end
    end
  endtask

  task automatic test_hazard();
    bank_stall = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd9; wr_data = 32'h11; #1; tick();
    wr_addr = 5'd9; wr_data = 32'h22; #1; tick();
    wr_valid = 1'b0; q_addr = 5'd9;
    #1;
    checks++; if (q_hit !== 1'b1 || q_data !== 32'h22) begin errors++; $display("FAIL hz_queued got %b/%h exp 1/22", q_hit, q_data); end
    q_addr = 5'd10;
    #1;
    checks++; if (q_hit !== 1'b0 || q_data !== 32'h0) begin errors++; $display("FAIL hz_other got %b/%h exp 0/0", q_hit, q_data); end
    q_addr = 5'd9; bank_stall = 1'b0;
    #1;
    tick();
    checks++; if (q_hit !== 1'b1 || q_data !== 32'h22) begin errors++; $display("FAIL hz_partial got %b/%h exp 1/22", q_hit, q_data); end
    tick();
    checks++; if (q_hit !== 1'b1 || q_data !== 32'h22) begin errors++; $display("FAIL hz_inflight got %b/%h exp 1/22", q_hit, q_data); end
    tick();
    checks++; if (q_hit !== 1'b0 || q_data !== 32'h0) begin errors++; $display("FAIL hz_drained got %b/%h exp 0/0", q_hit, q_data); end
  endtask

  task automatic test_back_to_back();
    bank_stall = 1'b0; wr_valid = 1'b1;
    for (int a = 1; a < 32; a++) begin
      wr_addr = 5'(a); wr_data = $urandom; q_addr = 5'(a - 1);
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready a=%0d got %b exp 1", a, wr_ready); end
      checks++; if (we_onehot !== m_we()) begin errors++; $display("FAIL b2b_we a=%0d got %h exp %h", a, we_onehot, m_we()); end
      if (a >= 3) begin
        checks++; if (we_onehot !== (32'd1 << (a - 2))) begin errors++; $display("FAIL b2b_order a=%0d got %h exp %h", a, we_onehot, 32'd1 << (a - 2)); end
      end
      checks++; if (q_data !== m_qdata(q_addr)) begin errors++; $display("FAIL b2b_qdata a=%0d got %h exp %h", a, q_data, m_qdata(q_addr)); end
      tick();
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (we_onehot !== m_we() || we_data !== inf_d) begin errors++; $display("FAIL b2b_tail got %h/%h exp %h/%h", we_onehot, we_data, m_we(), inf_d); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      wr_valid   = ($urandom_range(0, 3) != 0);
      wr_addr    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      bank_stall = ($urandom_range(0, 9) < 3);
      q_addr     = 5'($urandom_range(0, 4));
      #1;
      checks++; if (wr_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, wr_ready, m_ready()); end
      checks++; if (pend_cnt !== 2'(mq.size())) begin errors++; $display("FAIL rnd_pend n=%0d got %0d exp %0d", n, pend_cnt, mq.size()); end
      checks++; if (we_onehot !== m_we()) begin errors++; $display("FAIL rnd_we n=%0d got %h exp %h", n, we_onehot, m_we()); end
      checks++; if (we_data !== inf_d) begin errors++; $display("FAIL rnd_wdata n=%0d got %h exp %h", n, we_data, inf_d); end
      checks++; if (q_hit !== m_hit(q_addr)) begin errors++; $display("FAIL rnd_qhit n=%0d got %b exp %b", n, q_hit, m_hit(q_addr)); end
      checks++; if (q_data !== m_qdata(q_addr)) begin errors++; $display("FAIL rnd_qdata n=%0d got %h exp %h", n, q_data, m_qdata(q_addr)); end
      tick();
    end
    rst_n = 1'b1; wr_valid = 1'b0; bank_stall = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bank_stall = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd4; wr_data = 32'hA4; #1; tick();
    wr_addr = 5'd6; wr_data = 32'hA6; #1; tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL rmid_before got %0d exp 2", pend_cnt); end
    rst_n = 1'b0; bank_stall = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (pend_cnt !== 2'd0 || we_onehot !== 32'd0) begin errors++; $display("FAIL rmid_after got %0d/%h exp 0/0", pend_cnt, we_onehot); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (we_onehot !== 32'd0) begin errors++; $display("FAIL rmid_strobe%0d got %h exp 0", k, we_onehot); end
    end
  endtask

  initial begin
    inf_v = 1'b0; inf_a = '0; inf_d = '0;
    test_reset();
    test_single();
    test_addr0();
    test_stall_full();
    test_hazard();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
